// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source indices, register
// offsets and the arbiter state encoding.
package irq_pkg;

  localparam int NSRC      = 3;
  localparam int SRC_KEYB  = 0;
  localparam int SRC_MOUSE = 1;
  localparam int SRC_TIMER = 2;

  localparam logic [2:0] REG_STAT = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_TLO  = 3'd2;
  localparam logic [2:0] REG_THI  = 3'd3;
  localparam logic [2:0] REG_CNT0 = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NSRC-1:0] src_onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU memory-bus view of the interrupt controller register window.
interface irq_controller_if;
  logic [15:0] I_ADDR;
  logic [7:0]  I_DATA;
  logic        I_WREN;
  logic [7:0]  O_DATA;
  logic        O_SEL;

  modport master (output I_ADDR, output I_DATA, output I_WREN,
                  input  O_DATA, input  O_SEL);
  modport slave  (input  I_ADDR, input  I_DATA, input  I_WREN,
                  output O_DATA, output O_SEL);
endinterface

// File: rtl/irq_timer.sv
// Programmable interval timer: prescaler, 16-bit reload and down-counter,
// emitting a one-cycle expiry strobe when a tick lands on count 1.
module irq_timer #(
  parameter int PRESCALE = 25000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] reload_o,
  output logic        expire_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic          tick;

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  // A load on the same edge wins over any pending expiry.
  assign expire_o = tick && !load_i && (reload_q != 16'd0) && (count_q <= 16'd1);
  assign reload_o = reload_q;

  always_comb begin
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    if (load_i) begin
      reload_d = load_val_i;
      count_d  = load_val_i;
      presc_d  = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && reload_q != 16'd0) begin
        count_d = (count_q <= 16'd1) ? reload_q : count_q - 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      reload_q <= '0;
      count_q  <= '0;
    end else begin
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source pending counters, fixed-priority arbiter
// delivering level toggles, and the memory-mapped register window.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'hFFF0,
  parameter int          PRESCALE = 25000,
  parameter int          PEND_W   = 4
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  irq_controller_if.slave   bus,
  input  logic              KEYB_REQ,
  input  logic              MOUSE_REQ,
  output logic              IRQ_KEYB,
  output logic              IRQ_MOUSE,
  output logic              IRQ_TIMER
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              hit;
  logic [2:0]        offs;
  logic              wr_stat, wr_mask, wr_tlo, wr_thi;
  logic              timer_exp;
  logic [15:0]       reload;
  logic [NSRC-1:0]   req, grant, eligible, active, pend_nz;
  logic [PEND_W-1:0] pend [NSRC];
  logic [1:0]        pick;

  logic [NSRC-1:0]   mask_q, irq_q, irq_d;
  logic [7:0]        tlo_q;
  arb_state_e        state_q, state_d;
  logic [1:0]        src_q, src_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              sel_q;

  assign hit     = (bus.I_ADDR[15:3] == BASE[15:3]);
  assign offs    = bus.I_ADDR[2:0];
  assign wr_stat = bus.I_WREN && hit && (offs == REG_STAT);
  assign wr_mask = bus.I_WREN && hit && (offs == REG_MASK);
  assign wr_tlo  = bus.I_WREN && hit && (offs == REG_TLO);
  assign wr_thi  = bus.I_WREN && hit && (offs == REG_THI);

  irq_timer #(.PRESCALE(PRESCALE)) u_timer (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .load_i     (wr_thi),
    .load_val_i ({bus.I_DATA, tlo_q}),
    .reload_o   (reload),
    .expire_o   (timer_exp)
  );

  assign req[SRC_KEYB]  = KEYB_REQ;
  assign req[SRC_MOUSE] = MOUSE_REQ;
  assign req[SRC_TIMER] = timer_exp;

  // Counting ignores MASK; a request coinciding with delivery nets to zero.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      logic [PEND_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (req[gi] && grant[gi]) begin
          cnt_d = cnt_q;
        end else if (req[gi] && cnt_q != PEND_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (grant[gi]) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      assign pend[gi]    = cnt_q;
      assign pend_nz[gi] = |cnt_q;
    end
  endgenerate

  assign eligible = mask_q & pend_nz;
  assign active   = (state_q == ST_BUSY) ? src_onehot(src_q) : '0;

  always_comb begin
    pick = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) pick = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    grant   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_BUSY;
          src_d   = pick;
          grant   = src_onehot(pick);
        end
      end
      ST_BUSY: begin
        if (wr_stat && bus.I_DATA[src_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = irq_q ^ grant;
  end

  always_comb begin
    rdata_d = 8'h00;
    if (hit) begin
      case (offs)
        REG_STAT:         rdata_d = {1'b0, active, 1'b0, pend_nz};
        REG_MASK:         rdata_d = {5'b0, mask_q};
        REG_TLO:          rdata_d = tlo_q;
        REG_THI:          rdata_d = reload[15:8];
        REG_CNT0:         rdata_d = 8'(pend[0]);
        REG_CNT0 + 3'd1:  rdata_d = 8'(pend[1]);
        REG_CNT0 + 3'd2:  rdata_d = 8'(pend[2]);
        default:          rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      src_q   <= 2'd0;
      irq_q   <= '0;
      mask_q  <= '0;
      tlo_q   <= 8'h00;
      rdata_q <= 8'h00;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      sel_q   <= hit;
      if (wr_mask) mask_q <= bus.I_DATA[2:0];
      if (wr_tlo)  tlo_q  <= bus.I_DATA;
    end
  end

  assign bus.O_DATA = rdata_q;
  assign bus.O_SEL  = sel_q;
  assign IRQ_KEYB   = irq_q[SRC_KEYB];
  assign IRQ_MOUSE  = irq_q[SRC_MOUSE];
  assign IRQ_TIMER  = irq_q[SRC_TIMER];

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a cycle-level
// behavioural model of pending counts, priority delivery and timer period.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'hFFF0;
  localparam int          P    = 4;
  localparam int          PMAX = 15;

  logic CLOCK = 1'b0;
  logic RESET_N;
  logic KEYB_REQ, MOUSE_REQ;
  logic IRQ_KEYB, IRQ_MOUSE, IRQ_TIMER;

  irq_controller_if bus();

  irq_controller #(.BASE(BASE), .PRESCALE(P), .PEND_W(4)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .KEYB_REQ  (KEYB_REQ),
    .MOUSE_REQ (MOUSE_REQ),
    .IRQ_KEYB  (IRQ_KEYB),
    .IRQ_MOUSE (IRQ_MOUSE),
    .IRQ_TIMER (IRQ_TIMER)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_pend [3];
  int         m_act;
  bit [2:0]   m_irq, m_mask;
  bit [7:0]   m_tlo;
  bit [15:0]  m_rel;
  int         cyc, load_cyc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) m_pend[s] = 0;
    m_act = -1; m_irq = '0; m_mask = '0; m_tlo = '0; m_rel = '0; load_cyc = cyc;
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [2:0] ab, nz;
    int off;
    if (a < BASE || a > BASE + 16'd7) return 8'h00;
    ab = '0; nz = '0;
    if (m_act >= 0) ab[m_act] = 1'b1;
    for (int s = 0; s < 3; s++) nz[s] = (m_pend[s] != 0);
    off = int'(a - BASE);
    case (off)
      0: return {1'b0, ab, 1'b0, nz};
      1: return {5'b0, m_mask};
      2: return m_tlo;
      3: return m_rel[15:8];
      4: return 8'(m_pend[0]);
      5: return 8'(m_pend[1]);
      6: return 8'(m_pend[2]);
      default: return 8'h00;
    endcase
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit kb, input bit ms, input bit wr,
                      input logic [15:0] a, input logic [7:0] d);
    logic [7:0] exp_rd;
    bit         exp_sel, is_thi, is_stat, texp;
    bit [2:0]   rq;
    int         g;
    KEYB_REQ = kb; MOUSE_REQ = ms;
    bus.I_WREN = wr; bus.I_ADDR = a; bus.I_DATA = d;
    exp_sel = (a >= BASE && a <= BASE + 16'd7);
    exp_rd  = m_read(a);
    is_thi  = wr && (a == BASE + 16'd3);
    is_stat = wr && (a == BASE);
    texp = (m_rel != 0) && !is_thi && (((cyc + 1 - load_cyc) % (P * int'(m_rel))) == 0);
    rq = {texp, ms, kb};
    g = -1;
    if (m_act < 0) begin
      for (int s = 0; s < 3; s++)
        if (g < 0 && m_mask[s] && m_pend[s] > 0) g = s;
    end else if (is_stat && d[m_act]) begin
      m_act = -1;
    end
    for (int s = 0; s < 3; s++) begin
      if (rq[s] && g == s) m_pend[s] = m_pend[s];
      else if (rq[s])      m_pend[s] = (m_pend[s] < PMAX) ? m_pend[s] + 1 : PMAX;
      else if (g == s)     m_pend[s] = m_pend[s] - 1;
    end
    if (g >= 0) begin
      m_act = g;
      m_irq[g] = ~m_irq[g];
    end
    if (wr && a == BASE + 16'd1) m_mask = d[2:0];
    if (wr && a == BASE + 16'd2) m_tlo = d;
    if (is_thi) begin
      m_rel = {d, m_tlo};
      load_cyc = cyc + 1;
    end
    cyc++;
    @(posedge CLOCK);
    #1;
    chk("irq", {13'b0, IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, {13'b0, m_irq});
    chk("o_sel", {15'b0, bus.O_SEL}, {15'b0, exp_sel});
    chk("o_data", {8'b0, bus.O_DATA}, {8'b0, exp_rd});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0100, 8'h00);
  endtask

  task automatic do_wr(input logic [2:0] off, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, BASE + {13'b0, off}, d);
  endtask

  task automatic do_rd(input logic [2:0] off);
    step(1'b0, 1'b0, 1'b0, BASE + {13'b0, off}, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irq"}, {13'b0, IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, 16'h0);
    chk({tag, "_odata"}, {8'b0, bus.O_DATA}, 16'h0);
    chk({tag, "_osel"}, {15'b0, bus.O_SEL}, 16'h0);
  endtask

  initial begin
    int  tog;
    bit  prev;
    cyc = 0;
    RESET_N = 1'b0; KEYB_REQ = 0; MOUSE_REQ = 0;
    bus.I_ADDR = 16'h0; bus.I_DATA = 8'h0; bus.I_WREN = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    check_reset_outputs("por");
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Single request
    do_wr(3'd1, 8'h01);
    step(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    chk("single_no_toggle_yet", {15'b0, IRQ_KEYB}, 16'h0);
    idle();
    chk("single_toggle", {15'b0, IRQ_KEYB}, 16'h1);
    do_rd(3'd0);
    chk("single_stat_busy", {8'b0, bus.O_DATA}, 16'h10);
    do_wr(3'd0, 8'h01);
    do_rd(3'd0);
    chk("single_stat_idle", {8'b0, bus.O_DATA}, 16'h00);

    // Priority and gating
    do_wr(3'd1, 8'h07);
    step(1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
    idle();
    chk("prio_keyb", {15'b0, IRQ_KEYB}, 16'h0);
    chk("prio_mouse_held", {15'b0, IRQ_MOUSE}, 16'h0);
    do_wr(3'd0, 8'h04);
    do_rd(3'd0);
    chk("wrong_eoi_stat", {8'b0, bus.O_DATA}, 16'h12);
    do_wr(3'd0, 8'h01);
    chk("mouse_not_yet", {15'b0, IRQ_MOUSE}, 16'h0);
    idle();
    chk("mouse_after_eoi", {15'b0, IRQ_MOUSE}, 16'h1);
    do_wr(3'd0, 8'h02);

    // Saturation
    do_wr(3'd1, 8'h00);
    repeat (20) step(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    do_rd(3'd4);
    chk("sat_cnt", {8'b0, bus.O_DATA}, 16'd15);
    do_wr(3'd1, 8'h01);
    tog = 0; prev = IRQ_KEYB;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (IRQ_KEYB != prev) tog++;
      prev = IRQ_KEYB;
      do_wr(3'd0, 8'h01);
      if (IRQ_KEYB != prev) tog++;
      prev = IRQ_KEYB;
    end
    chk("sat_toggles", 16'(tog), 16'd15);

    // Timer: reload 3 at prescale 4 -> one expiry per 12 cycles
    do_wr(3'd1, 8'h04);
    do_wr(3'd2, 8'h03);
    do_wr(3'd3, 8'h00);
    tog = 0; prev = IRQ_TIMER;
    for (int i = 0; i < 66; i++) begin
      do_wr(3'd0, 8'h04);
      if (IRQ_TIMER != prev) tog++;
      prev = IRQ_TIMER;
    end
    chk("timer_toggles", 16'(tog), 16'd5);
    do_wr(3'd2, 8'h00);
    do_wr(3'd3, 8'h00);
    tog = 0; prev = IRQ_TIMER;
    for (int i = 0; i < 40; i++) begin
      do_wr(3'd0, 8'h04);
      if (IRQ_TIMER != prev) tog++;
      prev = IRQ_TIMER;
    end
    chk("timer_stopped", 16'(tog), 16'd0);

    // Request coinciding with delivery
    do_wr(3'd1, 8'h01);
    step(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    step(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    do_rd(3'd4);
    chk("coincide_cnt", {8'b0, bus.O_DATA}, 16'd1);
    do_wr(3'd0, 8'h01);
    idle();
    do_rd(3'd4);
    chk("coincide_drained", {8'b0, bus.O_DATA}, 16'd0);
    do_wr(3'd0, 8'h01);

    // Reset mid-operation
    do_wr(3'd1, 8'h00);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
    do_wr(3'd2, 8'h05);
    do_wr(3'd3, 8'h00);
    do_wr(3'd1, 8'h07);
    idle();
    #2 RESET_N = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge CLOCK);
    #1;
    check_reset_outputs("mid_rst_hold");
    @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
    for (int o = 0; o < 7; o++) begin
      do_rd(3'(o));
      chk("rst_read", {8'b0, bus.O_DATA}, 16'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit kb, ms;
      int op;
      kb = ($urandom_range(0, 3) == 0);
      ms = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 9);
      case (op)
        0, 1:    step(kb, ms, 1'b1, BASE, 8'($urandom_range(0, 7)));
        2:       step(kb, ms, 1'b1, BASE + 16'd1, 8'($urandom_range(0, 7)));
        3:       step(kb, ms, 1'b1, BASE + 16'd2, 8'($urandom_range(0, 5)));
        4:       step(kb, ms, 1'b1, BASE + 16'd3, ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
        5:       step(kb, ms, 1'b1, BASE - 16'd8 + 16'($urandom_range(0, 7)), 8'($urandom));
        6, 7, 8: step(kb, ms, 1'b0, BASE + 16'($urandom_range(0, 7)), 8'h00);
        default: step(kb, ms, 1'b0, 16'($urandom_range(0, 16'hFFEF)), 8'h00);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller for the 8-bit CPU's three toggle-style IRQ inputs (`IRQ_KEYB`, `IRQ_MOUSE`, `IRQ_TIMER`). It collects single-cycle request strobes from the keyboard and mouse, plus expiries of an internal programmable timer. It counts pending requests per source and delivers them one at a time, in fixed priority, as level toggles. Each toggle stays outstanding until the CPU writes an EOI. It sits on the CPU memory bus as a small memory-mapped register window, next to RAM.

## Interface
- `BASE`, 16'hFFF0: base address of the 8-byte register window (BASE[2:0] must be 0).
- `PRESCALE`, 25000: CLOCK cycles per timer tick (1 ms at 25 MHz); minimum 1.
- `PEND_W`, 4: width of each per-source pending counter.
- `CLOCK` in 1: system clock.
- `RESET_N` in 1: asynchronous reset, active low.
- `I_ADDR` in 16: CPU bus address.
- `I_DATA` in 8: CPU write data.
- `I_WREN` in 1: CPU write strobe.
- `O_DATA` out 8: registered read data for the window.
- `O_SEL` out 1: registered flag, "previous cycle's `I_ADDR` hit the window". The top level uses it to mux `O_DATA` over RAM data.
- `KEYB_REQ` in 1: one-cycle request strobe.
- `MOUSE_REQ` in 1: one-cycle request strobe.
- `IRQ_KEYB` out 1: toggle output to the CPU.
- `IRQ_MOUSE` out 1: toggle output to the CPU.
- `IRQ_TIMER` out 1: toggle output to the CPU.

## Operation
- Sources, in priority order: 0 = KEYB, 1 = MOUSE, 2 = TIMER.
- Register map (offset from `BASE`):
  - +0: read `{1'b0, active[2:0], 1'b0, pending_nz[2:0]}`; write bits[2:0] = EOI per source.
  - +1: MASK[2:0], read/write.
  - +2: TLO shadow, read/write.
  - +3: THI; a write commits reload = `{I_DATA, TLO}`. Reads return reload[15:8].
  - +4/+5/+6: pend_cnt of source 0/1/2, zero-extended, read-only.
  - +7: reads 0.
- Pending counters:
  - A request increments the counter, saturating at 2^PEND_W−1.
  - Requests are counted regardless of MASK.
  - A simultaneous increment and delivery decrement leaves the count unchanged.
- Arbiter FSM, with states IDLE and BUSY(src):
  - IDLE → BUSY(s) when s is the lowest-index source with MASK[s] set and pend_cnt[s] ≠ 0.
  - On that transition: IRQ_s toggles, pend_cnt[s] decrements, and active[s] sets.
  - BUSY(s) → IDLE on a write to +0 with bit s = 1.
  - EOI bits for non-active sources are ignored.
  - At most one source is active at any time.
- Clearing MASK[s] while BUSY(s) does not cancel the outstanding toggle.
- Timer:
  - The prescaler counts 0..PRESCALE−1; a tick is generated on wrap.
  - When reload = 0 the timer is stopped and the count is held.
  - Otherwise each tick decrements the count. A tick at count = 1 is an expiry: the timer-source request fires and the count reloads.
  - A THI write loads count = new reload and clears the prescaler.

## Timing
- Reset values: IRQ_* = 0, O_DATA = 0, O_SEL = 0. MASK, pend_cnt, active, TLO, reload, count and prescaler are all 0; the FSM is IDLE.
- Reads: `O_DATA` and `O_SEL` are registered from `I_ADDR`, giving 1-cycle latency, which matches RAM.
- Writes take effect at the clock edge where `I_WREN` = 1 and the address hits the window.
- Request-to-toggle latency, when idle and unmasked: the strobe at edge N bumps the count; the toggle occurs at edge N+1.
- EOI to next toggle: the EOI write at edge N returns the FSM to IDLE; the next toggle occurs no earlier than N+1.
- Simultaneous eligible requests: the lowest index wins; the others stay pending.
- Timer expiry: occurs at the tick edge; the TIMER pend_cnt increments at the same edge.
- Reset mid-operation clears everything asynchronously. The system reset must also clear the CPU's toggle shadow copies.

## Structure
- `irq_pkg` holds:
  - source indices (SRC_KEYB, SRC_MOUSE, SRC_TIMER);
  - register offsets (REG_STAT, REG_MASK, REG_TLO, REG_THI, REG_CNT0);
  - the FSM state encoding.
- The one natural sub-module is `irq_timer`: prescaler, reload, count, and an expiry strobe output, with a load port driven by the THI write.
- Pending counters, the arbiter and the bus decode live in `irq_controller`.

## Test plan
- **Reset:** assert RESET_N = 0 mid-run → all outputs 0; reads of +0..+6 return 0.
- **Single request:** MASK = 3'b001, one KEYB_REQ → IRQ_KEYB toggles 0→1 one cycle later; +0 reads 8'h10. Write 8'h01 to +0 → +0 reads 8'h00.
- **Priority and gating:**
  - With MASK = 3'b111, pulse KEYB_REQ and MOUSE_REQ in the same cycle → only IRQ_KEYB toggles.
  - After EOI 8'h01, IRQ_MOUSE toggles one cycle later.
  - A wrong-bit EOI (8'h04) while KEYB is active has no effect.
- **Saturation:** MASK = 0, 20 KEYB_REQ strobes → +4 reads 15. Then set MASK = 1 and loop EOIs → exactly 15 toggles of IRQ_KEYB.
- **Timer:** PRESCALE = 4, write TLO = 3, THI = 0 → an expiry every 12 cycles; IRQ_TIMER toggles once per EOI. Writing THI/TLO = 0 stops further expiries.
- **Request during delivery:** KEYB_REQ in the same cycle as the delivery decrement → pend_cnt is unchanged and the request is not lost.
